// File: rtl/l2_bus_pkg.sv
// l2_bus_pkg: definitions shared by the L1 caches and the L2 request arbiter.
//   - L2 command encoding (NOP/READ_OUT/WRITE_OUT; 2'b11 reserved)
//   - line address width, queue entry width, source ids
//   - arbiter state encoding
//   - is_req(): true for a command that must be forwarded to L2
package l2_bus_pkg;

  localparam logic [1:0] NOP       = 2'b00;
  localparam logic [1:0] READ_OUT  = 2'b01;
  localparam logic [1:0] WRITE_OUT = 2'b10;

  localparam int LINE_ADDR_W = 26;
  localparam int ENTRY_W     = 2 + LINE_ADDR_W;

  localparam logic SRC_DC = 1'b0;
  localparam logic SRC_IC = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // The reserved code 2'b11 is not a request.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == READ_OUT) || (cmd == WRITE_OUT);
  endfunction

endpackage

// File: rtl/l2_request_arbiter_if.sv
// l2_request_arbiter_if: command port toward L2.
//   cmd   [1:0]  command presented to L2 (NOP = nothing presented)
//   add   [25:0] line address
//   src          0 data cache, 1 instruction cache
//   ready        L2 accepts the presented command at this edge
// master: arbiter side, slave: L2 side.
interface l2_request_arbiter_if;
  import l2_bus_pkg::*;

  logic [1:0]             cmd;
  logic [LINE_ADDR_W-1:0] add;
  logic                   src;
  logic                   ready;

  modport master (output cmd, output add, output src, input ready);
  modport slave  (input cmd, input add, input src, output ready);

endinterface

// File: rtl/l2_req_fifo.sv
// l2_req_fifo: per-source request queue.
//   clk, rst      clock, asynchronous active-high reset
//   wr_en/wr_data write request; accepted when not full, or when full and
//                 a read happens at the same edge
//   rd_en         pop the head (ignored when empty)
//   head          current head entry ({cmd, add})
//   empty, full   occupancy flags; full is registered from the post-edge count
module l2_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_next;
  logic              do_rd;
  logic              wr_ok;

  assign do_rd = rd_en && !empty;
  // When full, the slot being written is the one the head leaves this edge.
  assign wr_ok = wr_en && (!full || do_rd);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (wr_ok && !do_rd)
      count_next = count + 1'b1;
    else if (!wr_ok && do_rd)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_C);
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: shares the L2 command port between the data cache and
// the instruction cache. Requests are buffered per source and forwarded one at
// a time, round-robin on ties.
//   clk, rst              clock, asynchronous active-high reset
//   dc_cmd/dc_add         data-cache request (fire-and-forget)
//   ic_cmd/ic_add         instruction-cache request
//   l2                    command port toward L2 (master side)
//   dc_full/ic_full       queue holds FIFO_DEPTH entries
//   dc_grants/ic_grants   commands accepted by L2 per source
//   dc_drops/ic_drops     requests lost to a full queue, saturating
//
// state | meaning
// IDLE  | nothing presented, l2.cmd = NOP
// ISSUE | command held on l2 until l2.ready
module l2_request_arbiter
  import l2_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             dc_cmd,
  input  logic [LINE_ADDR_W-1:0] dc_add,
  input  logic [1:0]             ic_cmd,
  input  logic [LINE_ADDR_W-1:0] ic_add,
  l2_request_arbiter_if.master   l2,
  output logic                   dc_full,
  output logic                   ic_full,
  output logic [31:0]            dc_grants,
  output logic [31:0]            ic_grants,
  output logic [15:0]            dc_drops,
  output logic [15:0]            ic_drops
);

  arb_state_t             state;
  logic                   last_grant;
  logic [1:0]             cmd_q;
  logic [LINE_ADDR_W-1:0] add_q;
  logic                   src_q;

  logic [ENTRY_W-1:0] dc_head;
  logic [ENTRY_W-1:0] ic_head;
  logic [ENTRY_W-1:0] head_sel;
  logic dc_empty, ic_empty;
  logic dc_req, ic_req;
  logic dc_rd, ic_rd;
  logic dc_drop, ic_drop;
  logic done, can_load, eff_last, grant_ic, pop;

  assign dc_req = is_req(dc_cmd);
  assign ic_req = is_req(ic_cmd);

  l2_req_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .DATA_W(ENTRY_W)) u_dc_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (dc_req),
    .wr_data ({dc_cmd, dc_add}),
    .rd_en   (dc_rd),
    .head    (dc_head),
    .empty   (dc_empty),
    .full    (dc_full)
  );

  l2_req_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .DATA_W(ENTRY_W)) u_ic_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ic_req),
    .wr_data ({ic_cmd, ic_add}),
    .rd_en   (ic_rd),
    .head    (ic_head),
    .empty   (ic_empty),
    .full    (ic_full)
  );

  // A completing transfer updates last_grant before the next pick, so
  // back-to-back ties alternate cycle by cycle.
  assign done     = (state == ISSUE) && l2.ready;
  assign can_load = (state == IDLE) || l2.ready;
  assign eff_last = done ? src_q : last_grant;
  assign grant_ic = !ic_empty && (dc_empty || (eff_last == SRC_DC));
  assign pop      = can_load && (!dc_empty || !ic_empty);
  assign dc_rd    = pop && !grant_ic;
  assign ic_rd    = pop && grant_ic;
  assign head_sel = grant_ic ? ic_head : dc_head;

  assign dc_drop = dc_req && dc_full && !dc_rd;
  assign ic_drop = ic_req && ic_full && !ic_rd;

  assign l2.cmd = cmd_q;
  assign l2.add = add_q;
  assign l2.src = src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_IC;
      cmd_q      <= NOP;
      add_q      <= '0;
      src_q      <= SRC_DC;
      dc_grants  <= '0;
      ic_grants  <= '0;
      dc_drops   <= '0;
      ic_drops   <= '0;
    end else begin
      if (done) begin
        if (src_q == SRC_IC)
          ic_grants <= ic_grants + 1'b1;
        else
          dc_grants <= dc_grants + 1'b1;
        last_grant <= src_q;
      end

      if (pop) begin
        state <= ISSUE;
        cmd_q <= head_sel[ENTRY_W-1:LINE_ADDR_W];
        add_q <= head_sel[LINE_ADDR_W-1:0];
        src_q <= grant_ic;
      end else if (done) begin
        state <= IDLE;
        cmd_q <= NOP;
      end

      if (dc_drop && (dc_drops != 16'hFFFF))
        dc_drops <= dc_drops + 1'b1;
      if (ic_drop && (ic_drops != 16'hFFFF))
        ic_drops <= ic_drops + 1'b1;
    end
  end

endmodule
